// File: rtl/msg_frame_buffer.sv
// -----------------------------------------------------------------------------
// msg_frame_buffer
//
// Captures FIELD_N payload bytes. It then emits a paced frame made of a fixed
// header, the captured payload and a fixed trailer. Consecutive output bytes
// are separated by exactly PACE idle cycles. The output side is a
// valid/ready handshake.
//
// Ports
//   clk        in   1  single clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   in_valid   in   1  payload byte strobe (one byte per high cycle)
//   in_data    in   8  payload byte
//   abort      in   1  drop the frame in progress and go back to capture
//   clr_ovr    in   1  clear the sticky overrun flag
//   out_ready  in   1  downstream accepts out_data while out_valid is high
//   out_valid  out  1  out_data holds a frame byte
//   out_data   out  8  frame byte (8'h00 while out_valid is low)
//   busy       out  1  a frame is being sent (SEND or GAP)
//   done       out  1  one-cycle pulse after the last frame byte is accepted
//   overrun    out  1  sticky: a payload byte arrived while not capturing
// -----------------------------------------------------------------------------
module msg_frame_buffer #(
  parameter int                 FIELD_N = 8,
  parameter int                 HDR_N   = 4,
  parameter logic [8*HDR_N-1:0] HDR     = 32'h5A676A3A,
  parameter int                 TRL_N   = 3,
  parameter logic [8*TRL_N-1:0] TRL     = 24'h646179,
  parameter int                 PACE    = 4500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       abort,
  input  logic       clr_ovr,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int MSG_LEN = HDR_N + FIELD_N + TRL_N;
  localparam int IDX_W   = $clog2(MSG_LEN);
  localparam int CNT_W   = (FIELD_N > 1) ? $clog2(FIELD_N) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FIELD_N - 1);
  localparam logic [15:0]      GAP_LAST = 16'(PACE - 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SEND    = 2'd1,
    S_GAP     = 2'd2
  } state_t;

  state_t             r_state,     w_state_nxt;
  logic [CNT_W-1:0]   r_cnt,       w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx,       w_idx_nxt;
  logic [15:0]        r_gap,       w_gap_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [7:0]         r_out_data,  w_out_data_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_done,      w_done_nxt;
  logic               r_ovr,       w_ovr_nxt;
  logic [7:0]         r_field [FIELD_N];

  logic               w_fld_we;
  logic               w_ovr_set;
  logic [IDX_W-1:0]   w_sel_idx;
  int                 w_k;
  logic [8*HDR_N-1:0] w_hdr_sh;
  logic [8*TRL_N-1:0] w_trl_sh;
  logic [7:0]         w_byte;

  // Byte that will be presented when entering SEND. Coming from COLLECT
  // it is always byte 0. Coming from GAP, r_idx has already been advanced
  // to the next byte. Selecting only from registers keeps this path free
  // of any dependency on the next-state logic.
  always_comb begin
    w_sel_idx = (r_state == S_GAP) ? r_idx : '0;
    w_k       = int'(w_sel_idx);
    w_hdr_sh  = HDR >> (8 * (HDR_N - 1 - w_k));
    w_trl_sh  = TRL >> (8 * (TRL_N - 1 - (w_k - HDR_N - FIELD_N)));
    w_byte    = 8'h00;
    if (w_k < HDR_N)
      w_byte = w_hdr_sh[7:0];
    else if (w_k < HDR_N + FIELD_N)
      w_byte = r_field[CNT_W'(w_k - HDR_N)];
    else
      w_byte = w_trl_sh[7:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_nxt       = r_idx;
    w_gap_nxt       = r_gap;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_done_nxt      = 1'b0;
    w_fld_we        = 1'b0;
    w_ovr_set       = 1'b0;

    if (abort) begin
      // Abort has top priority. A byte strobed in the same cycle is
      // ignored and is not treated as an overrun.
      w_state_nxt     = S_COLLECT;
      w_cnt_nxt       = '0;
      w_idx_nxt       = '0;
      w_gap_nxt       = '0;
      w_out_valid_nxt = 1'b0;
      w_out_data_nxt  = 8'h00;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (in_valid) begin
            w_fld_we = 1'b1;
            if (r_cnt == LAST_CNT) begin
              // Last payload byte: present header byte 0 on the next cycle.
              w_cnt_nxt       = '0;
              w_idx_nxt       = '0;
              w_gap_nxt       = '0;
              w_state_nxt     = S_SEND;
              w_out_valid_nxt = 1'b1;
              w_out_data_nxt  = w_byte;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end

        S_SEND: begin
          w_ovr_set = in_valid;
          if (out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = 8'h00;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = S_COLLECT;
              w_idx_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_GAP;
              w_idx_nxt   = r_idx + 1'b1;
              w_gap_nxt   = '0;
            end
          end
        end

        S_GAP: begin
          w_ovr_set = in_valid;
          // r_gap counts 0..PACE-1. Each value is one cycle with out_valid
          // low, so the idle gap is exactly PACE cycles.
          if (r_gap == GAP_LAST) begin
            w_gap_nxt       = '0;
            w_state_nxt     = S_SEND;
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_byte;
          end else begin
            w_gap_nxt = r_gap + 16'd1;
          end
        end

        default: begin
          w_state_nxt     = S_COLLECT;
          w_out_valid_nxt = 1'b0;
          w_out_data_nxt  = 8'h00;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt != S_COLLECT);
    // When set and clear happen together, set wins.
    if (w_ovr_set)    w_ovr_nxt = 1'b1;
    else if (clr_ovr) w_ovr_nxt = 1'b0;
    else              w_ovr_nxt = r_ovr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_COLLECT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_gap       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_gap       <= w_gap_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_ovr       <= w_ovr_nxt;
    end
  end

  // Payload storage. Values persist across frames until they are
  // overwritten, and a restarted capture writes again from field[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIELD_N; i++) r_field[i] <= 8'h00;
    end else if (w_fld_we) begin
      r_field[r_cnt] <= in_data;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_msg_frame_buffer.sv
module tb_msg_frame_buffer;

  localparam int FN   = 8;
  localparam int HN   = 4;
  localparam int TN   = 3;
  localparam int PACE = 4;
  localparam int ML   = HN + FN + TN;
  localparam logic [31:0] HDRV = 32'h5A676A3A;
  localparam logic [23:0] TRLV = 24'h646179;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, abort, clr_ovr, out_ready;
  logic [7:0] in_data;
  logic       out_valid, busy, done, overrun;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  msg_frame_buffer #(.FIELD_N(FN), .HDR_N(HN), .HDR(HDRV), .TRL_N(TN), .TRL(TRLV), .PACE(PACE)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .abort(abort),
    .clr_ovr(clr_ovr), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  // m_fq: payload bytes captured so far; m_tx: bytes of the frame still to
  // be delivered (front is the one presented); m_gap: idle cycles left.
  logic [7:0] m_fq[$];
  logic [7:0] m_tx[$];
  int         m_gap;
  bit         m_valid, m_done, m_ovr;

  task automatic m_reset();
    m_fq.delete(); m_tx.delete();
    m_gap = 0; m_valid = 0; m_done = 0; m_ovr = 0;
  endtask

  task automatic m_step(input bit v, input logic [7:0] d, input bit ab, input bit clr, input bit rdy);
    bit set;
    set    = 0;
    m_done = 0;
    if (ab) begin
      m_fq.delete(); m_tx.delete(); m_valid = 0; m_gap = 0;
    end else if (m_tx.size() == 0) begin
      if (v) begin
        m_fq.push_back(d);
        if (m_fq.size() == FN) begin
          for (int i = 0; i < HN; i++) m_tx.push_back(8'(HDRV >> (8 * (HN - 1 - i))));
          foreach (m_fq[i]) m_tx.push_back(m_fq[i]);
          for (int i = 0; i < TN; i++) m_tx.push_back(8'(TRLV >> (8 * (TN - 1 - i))));
          m_fq.delete();
          m_valid = 1;
        end
      end
    end else begin
      set = v;
      if (m_valid) begin
        if (rdy) begin
          m_tx.delete(0);
          m_valid = 0;
          if (m_tx.size() == 0) m_done = 1;
          else m_gap = PACE;
        end
      end else begin
        m_gap--;
        if (m_gap == 0) m_valid = 1;
      end
    end
    if (set)      m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic chk_all();
    logic [7:0] ed;
    ed = 8'h00;
    if (m_valid) ed = m_tx[0];
    chk("model out_valid", out_valid, m_valid);
    chk("model out_data", out_data, ed);
    chk("model busy", busy, (m_tx.size() > 0));
    chk("model done", done, m_done);
    chk("model overrun", overrun, m_ovr);
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic cyc(input bit v, input logic [7:0] d, input bit ab, input bit clr, input bit rdy);
    in_valid = v; in_data = d; abort = ab; clr_ovr = clr; out_ready = rdy;
    @(posedge clk);
    m_step(v, d, ab, clr, rdy);
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    in_valid = 0; in_data = 8'h00; abort = 0; clr_ovr = 0; out_ready = 0;
    rst = 1'b1;
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 8'h00);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset overrun", overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic feed(input logic [63:0] pay);
    for (int i = 0; i < FN; i++) cyc(1'b1, 8'(pay >> (8 * (FN - 1 - i))), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    bit seen;
    seen = 0;
    for (int c = 0; c < 300 && !seen; c++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      if (done) seen = 1;
    end
    chk("drain done", seen, 1);
  endtask

  // Feed a payload and check the produced frame against an expected table.
  task automatic run_frame(input logic [63:0] pay, input logic [119:0] exp, input string nm);
    int got, lows, dones;
    feed(pay);
    chk({nm, " latency"}, out_valid, 1);
    got = 0; lows = 0; dones = 0;
    for (int c = 0; c < 300 && dones == 0; c++) begin
      if (out_valid) begin
        if (got < ML) chk({nm, " byte"}, out_data, 8'(exp >> (8 * (ML - 1 - got))));
        if (got > 0) chk({nm, " gap"}, lows, PACE);
        got++; lows = 0;
      end else begin
        lows++;
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      if (done) dones++;
    end
    chk({nm, " count"}, got, ML);
    chk({nm, " done"}, dones, 1);
  endtask

  typedef struct {
    logic [63:0]  pay;
    logic [119:0] exp;
  } rec_t;
  rec_t tbl[4];

  int acc;
  bit rv, rab, rclr, rrdy;
  logic [7:0] rd;

  initial begin
    tbl[0] = '{64'h3230303031303239, 120'h5A676A3A_3230303031303239_646179};
    tbl[1] = '{64'h0000000000000000, 120'h5A676A3A_0000000000000000_646179};
    tbl[2] = '{64'hFFFFFFFFFFFFFFFF, 120'h5A676A3A_FFFFFFFFFFFFFFFF_646179};
    tbl[3] = '{64'h0102030405060708, 120'h5A676A3A_0102030405060708_646179};

    rst = 1'b0;
    #1;
    do_reset();

    // Table-driven frames, out_ready tied high.
    for (int t = 0; t < 4; t++) run_frame(tbl[t].pay, tbl[t].exp, "table frame");

    // Back-pressure on byte 2.
    feed(tbl[0].pay);
    acc = 0;
    for (int c = 0; c < 100 && !(out_valid && acc == 2); c++) begin
      if (out_valid) acc++;
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    chk("stall reached byte 2", out_valid && acc == 2, 1);
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("stall valid held", out_valid, 1);
      chk("stall data held", out_data, 8'h6A);
    end
    drain();

    // Overrun during GAP, then clear, then set and clear together.
    feed(tbl[3].pay);
    acc = 0;
    for (int c = 0; c < 50 && !(acc > 0 && !out_valid); c++) begin
      if (out_valid) acc++;
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    chk("in gap", busy && !out_valid, 1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("overrun set", overrun, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("overrun cleared", overrun, 0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    chk("overrun set wins", overrun, 1);
    drain();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("overrun clr idle", overrun, 0);

    // Abort while presenting byte 6; in_valid on the abort cycle is ignored.
    feed(tbl[2].pay);
    acc = 0;
    for (int c = 0; c < 100 && !(out_valid && acc == 6); c++) begin
      if (out_valid) acc++;
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    chk("abort reached byte 6", out_valid && acc == 6, 1);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    chk("abort out_valid", out_valid, 0);
    chk("abort done", done, 0);
    chk("abort overrun", overrun, 0);
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk("abort no done", done, 0);
    end
    run_frame(tbl[0].pay, tbl[0].exp, "after abort");

    // Reset after 3 captured bytes.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1);
    do_reset();
    run_frame(tbl[3].pay, tbl[3].exp, "after reset");

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rv   = ($urandom_range(0, 9) < 6);
      rd   = 8'($urandom);
      rab  = ($urandom_range(0, 299) == 0);
      rclr = ($urandom_range(0, 15) == 0);
      rrdy = ($urandom_range(0, 3) != 0);
      cyc(rv, rd, rab, rclr, rrdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
